// File: rtl/jk_excitation_driver_pkg.sv
// Shared definitions for the JK excitation driver.
// Contents:
//   op_t     command opcodes carried on tgt_op
//   state_t  driver sequencing states
//   ROT_N    number of redundant J/K lines per flop
//   excite() JK excitation for one bit: present q, wanted next qn and
//            don't-care fill tog -> {j, k}
package jk_drv_pkg;

  typedef enum logic [1:0] {
    OP_STEP   = 2'b00,
    OP_PRESET = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_HOLD   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE_HI,
    S_PULSE_LO,
    S_SAMPLE,
    S_RESP
  } state_t;

  localparam int ROT_N = 3;

  // 0->0: J=0 K=x   0->1: J=1 K=x   1->0: J=x K=1   1->1: J=x K=0
  function automatic logic [1:0] excite(input logic q, input logic qn, input logic tog);
    logic j;
    logic k;
    j = q ? tog : qn;
    k = q ? ~qn : tog;
    return {j, k};
  endfunction

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Command / response handshake bundle of the JK excitation driver.
// Signals:
//   tgt_valid/tgt_ready  command handshake
//   tgt_op, tgt_q, tgt_tog  command payload
//   rsp_valid/rsp_ready  response handshake
//   rsp_match, rsp_q     response payload
// master: the command source; slave: the driver.
interface jk_excitation_driver_if #(parameter int W = 4);
  logic         tgt_valid;
  logic         tgt_ready;
  logic [1:0]   tgt_op;
  logic [W-1:0] tgt_q;
  logic         tgt_tog;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_match;
  logic [W-1:0] rsp_q;

  modport master (
    output tgt_valid, tgt_op, tgt_q, tgt_tog, rsp_ready,
    input  tgt_ready, rsp_valid, rsp_match, rsp_q
  );

  modport slave (
    input  tgt_valid, tgt_op, tgt_q, tgt_tog, rsp_ready,
    output tgt_ready, rsp_valid, rsp_match, rsp_q
  );
endinterface

// File: rtl/jk_excitation_driver_line_spread.sv
// Spreads one J or K bit over the three ANDed bank inputs.
// Ports:
//   bit_in  wanted value of the ANDed result
//   rot     which line (0..2) carries the low level when bit_in=0
//   lines   three line values, lines[0] = line 1
// A 1 drives every line high; a 0 pulls only the rotated line low so each
// AND input gets exercised as the sole deciding input over time.
module jk_line_spread (
  input  logic       bit_in,
  input  logic [1:0] rot,
  output logic [2:0] lines
);
  assign lines[0] = bit_in | (rot != 2'd0);
  assign lines[1] = bit_in | (rot != 2'd1);
  assign lines[2] = bit_in | (rot != 2'd2);
endmodule

// File: rtl/jk_excitation_driver.sv
// Self-check stimulus driver for a bank of W JK master-slave flops.
// Ports:
//   clk, CLR            clock, asynchronous active-high reset
//   bus (slave)         command in (tgt_*), response out (rsp_*)
//   ff_j1..3, ff_k1..3  registered J/K lines to the bank
//   ff_pre, ff_clr      registered bank preset / clear
//   ff_clk              registered one-cycle bank clock pulse
//   q_in                bank Q, captured in SAMPLE
//   err_cnt             saturating mismatch counter
// Sequence per command: IDLE -> SETUP -> PULSE_HI -> PULSE_LO -> SAMPLE -> RESP.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int W     = 4,
  parameter int ERR_W = 16
) (
  input  logic                clk,
  input  logic                CLR,
  jk_excitation_driver_if.slave bus,
  output logic [W-1:0]        ff_j1,
  output logic [W-1:0]        ff_j2,
  output logic [W-1:0]        ff_j3,
  output logic [W-1:0]        ff_k1,
  output logic [W-1:0]        ff_k2,
  output logic [W-1:0]        ff_k3,
  output logic                ff_pre,
  output logic                ff_clr,
  output logic                ff_clk,
  input  logic [W-1:0]        q_in,
  output logic [ERR_W-1:0]    err_cnt
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t       state, next_state;
  op_t          op_r;
  logic [W-1:0] tgt_q_r;
  logic [W-1:0] model;
  logic [W-1:0] expected;
  logic [1:0]   rot;
  logic         rdy_r, vld_r, match_r;
  logic [W-1:0] rsp_q_r;
  logic         accept;

  logic [W-1:0] j_bit, k_bit;
  logic         zero_lines;
  logic [W-1:0] j1_s, j2_s, j3_s, k1_s, k2_s, k3_s;

  logic [W-1:0] j1_d, j2_d, j3_d, k1_d, k2_d, k3_d;
  logic         pre_d, clkp_d, clr_d, rdy_d, vld_d;

  assign accept        = bus.tgt_valid && rdy_r;
  assign bus.tgt_ready = rdy_r;
  assign bus.rsp_valid = vld_r;
  assign bus.rsp_match = match_r;
  assign bus.rsp_q     = rsp_q_r;

  // Excitation is formed from the incoming command so it can be registered
  // on the accept edge and be settled for the whole SETUP cycle.
  always_comb begin
    j_bit      = '0;
    k_bit      = '0;
    zero_lines = 1'b0;
    case (op_t'(bus.tgt_op))
      OP_STEP: begin
        for (int i = 0; i < W; i++) begin
          {j_bit[i], k_bit[i]} = excite(model[i], bus.tgt_q[i], bus.tgt_tog);
        end
      end
      OP_HOLD: begin
        j_bit = '0;
        k_bit = '0;
      end
      default: zero_lines = 1'b1;
    endcase
  end

  for (genvar i = 0; i < W; i++) begin : g_spread
    logic [2:0] jl, kl;
    jk_line_spread u_j (.bit_in(j_bit[i]), .rot(rot), .lines(jl));
    jk_line_spread u_k (.bit_in(k_bit[i]), .rot(rot), .lines(kl));
    assign j1_s[i] = jl[0];
    assign j2_s[i] = jl[1];
    assign j3_s[i] = jl[2];
    assign k1_s[i] = kl[0];
    assign k2_s[i] = kl[1];
    assign k3_s[i] = kl[2];
  end

  always_comb begin
    case (op_r)
      OP_STEP:   expected = tgt_q_r;
      OP_PRESET: expected = '1;
      OP_CLEAR:  expected = '0;
      default:   expected = model;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (accept) next_state = S_SETUP;
      S_SETUP:    next_state = S_PULSE_HI;
      S_PULSE_HI: next_state = S_PULSE_LO;
      S_PULSE_LO: next_state = S_SAMPLE;
      S_SAMPLE:   next_state = S_RESP;
      S_RESP:     if (bus.rsp_ready) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered bank and handshake outputs
  always_comb begin
    j1_d   = ff_j1;
    j2_d   = ff_j2;
    j3_d   = ff_j3;
    k1_d   = ff_k1;
    k2_d   = ff_k2;
    k3_d   = ff_k3;
    pre_d  = 1'b0;
    clkp_d = 1'b0;
    clr_d  = 1'b0;
    rdy_d  = (next_state == S_IDLE);
    vld_d  = (next_state == S_RESP);
    if (accept) begin
      j1_d = zero_lines ? '0 : j1_s;
      j2_d = zero_lines ? '0 : j2_s;
      j3_d = zero_lines ? '0 : j3_s;
      k1_d = zero_lines ? '0 : k1_s;
      k2_d = zero_lines ? '0 : k2_s;
      k3_d = zero_lines ? '0 : k3_s;
    end else if (state == S_SAMPLE) begin
      j1_d = '0;
      j2_d = '0;
      j3_d = '0;
      k1_d = '0;
      k2_d = '0;
      k3_d = '0;
    end
    if (next_state == S_PULSE_HI) begin
      case (op_r)
        OP_PRESET: pre_d  = 1'b1;
        OP_CLEAR:  clr_d  = 1'b1;
        default:   clkp_d = 1'b1;
      endcase
    end
  end

  // ff_clr resets high so the bank is held cleared, matching model=0.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      ff_j1  <= '0;
      ff_j2  <= '0;
      ff_j3  <= '0;
      ff_k1  <= '0;
      ff_k2  <= '0;
      ff_k3  <= '0;
      ff_pre <= 1'b0;
      ff_clk <= 1'b0;
      ff_clr <= 1'b1;
      rdy_r  <= 1'b0;
      vld_r  <= 1'b0;
    end else begin
      ff_j1  <= j1_d;
      ff_j2  <= j2_d;
      ff_j3  <= j3_d;
      ff_k1  <= k1_d;
      ff_k2  <= k2_d;
      ff_k3  <= k3_d;
      ff_pre <= pre_d;
      ff_clk <= clkp_d;
      ff_clr <= clr_d;
      rdy_r  <= rdy_d;
      vld_r  <= vld_d;
    end
  end

  // Sample stage: capture Q, update model and mismatch count
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      rot     <= 2'd0;
      model   <= '0;
      rsp_q_r <= '0;
      match_r <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (accept) rot <= (rot == 2'(ROT_N - 1)) ? 2'd0 : rot + 2'd1;
      if (state == S_SAMPLE) begin
        rsp_q_r <= q_in;
        match_r <= (q_in == expected);
        model   <= q_in;
        if (q_in != expected) err_cnt <= sat_inc(err_cnt);
      end
    end
  end

  // Command payload is data only; it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r    <= op_t'(bus.tgt_op);
      tgt_q_r <= bus.tgt_q;
    end
  end

endmodule
